// File: rtl/unpacked_mx_fifo.sv
// unpacked_mx_fifo: first-word-fall-through FIFO for MX blocks.
// Each entry holds IN_SIZE mantissas plus one shared exponent. These values
// are always written and read together in the same entry.
// Optional feature: define MX_FIFO_BYPASS_EN to let a block pass straight
// through while the FIFO is empty. In that case the output is combinational
// from the input.
module unpacked_mx_fifo #(
    parameter int DEPTH     = 16,
    parameter int MAN_WIDTH = 4,
    parameter int EXP_WIDTH = 8,
    parameter int IN_SIZE   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MAN_WIDTH-1:0]         mdata_in [IN_SIZE-1:0],
    input  logic [EXP_WIDTH-1:0]         edata_in,
    input  logic                         data_in_valid,
    output logic                         data_in_ready,
    output logic [MAN_WIDTH-1:0]         mdata_out [IN_SIZE-1:0],
    output logic [EXP_WIDTH-1:0]         edata_out,
    output logic                         data_out_valid,
    input  logic                         data_out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Storage is not reset. Entries are only visible through rd_ptr/count,
    // so any stale contents are never observed.
    logic [MAN_WIDTH-1:0] mem_m [DEPTH][IN_SIZE];
    logic [EXP_WIDTH-1:0] mem_e [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             bypass_take;

    // Pointer increment that wraps at DEPTH-1. This works for any DEPTH,
    // including values that are not a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    assign full          = (count == CNT_W'(DEPTH));
    assign empty         = (count == '0);
    assign data_in_ready = !full;

`ifdef MX_FIFO_BYPASS_EN
    // An empty FIFO with a ready consumer hands the input block straight out.
    assign bypass_take = empty && data_in_valid && data_out_ready && !rst;
`else
    assign bypass_take = 1'b0;
`endif

    // Handshakes. A bypassed block is never stored. The pop condition only
    // looks at real stored entries.
    assign push = data_in_valid && data_in_ready && !bypass_take;
    assign pop  = !empty && data_out_ready;

    // Control state: pointers and occupancy, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Storage write: the whole MX block lands in a single entry
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < IN_SIZE; i++)
                mem_m[wr_ptr][i] <= mdata_in[i];
            mem_e[wr_ptr] <= edata_in;
        end
    end

    // Output mux: show the head entry, show the bypassed input, or drive zeros
    always_comb begin
        data_out_valid = 1'b0;
        edata_out      = '0;
        for (int i = 0; i < IN_SIZE; i++)
            mdata_out[i] = '0;
        if (!empty) begin
            data_out_valid = 1'b1;
            edata_out      = mem_e[rd_ptr];
            for (int i = 0; i < IN_SIZE; i++)
                mdata_out[i] = mem_m[rd_ptr][i];
        end
`ifdef MX_FIFO_BYPASS_EN
        else if (data_in_valid && !rst) begin
            data_out_valid = 1'b1;
            edata_out      = edata_in;
            for (int i = 0; i < IN_SIZE; i++)
                mdata_out[i] = mdata_in[i];
        end
`endif
    end

endmodule

// File: doc/unpacked_mx_fifo.md
UNPACKED_MX_FIFO -- requirements
Module: unpacked_mx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of storage entries (integer >= 2, not required to be a power of two).
REQ-002 The block SHALL have parameter MAN_WIDTH, default 4, meaning the width of each mantissa element.
REQ-003 The block SHALL have parameter EXP_WIDTH, default 8, meaning the width of the shared exponent.
REQ-004 The block SHALL have parameter IN_SIZE, default 1, meaning the number of mantissa elements per MX block.
REQ-005 The block SHALL have one clock, clk, and one reset, rst, which is asynchronous and active-high.
REQ-006 The ports SHALL be as follows:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- mdata_in  input  unpacked [IN_SIZE-1:0] of MAN_WIDTH  mantissa vector in
- edata_in  input  EXP_WIDTH  shared exponent in
- data_in_valid  input  1  upstream valid
- data_in_ready  output  1  upstream ready
- mdata_out  output  unpacked [IN_SIZE-1:0] of MAN_WIDTH  mantissa vector out
- edata_out  output  EXP_WIDTH  shared exponent out
- data_out_valid  output  1  downstream valid
- data_out_ready  input  1  downstream ready
- count  output  $clog2(DEPTH+1)  occupancy
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Function
REQ-007 Each entry SHALL store one complete MX block: all IN_SIZE mantissas plus the exponent, kept together and never split.
REQ-008 A push SHALL occur on a rising clk edge when data_in_valid && data_in_ready.
REQ-009 A pop SHALL occur on a rising clk edge when data_out_valid && data_out_ready.
REQ-010 data_in_ready SHALL equal !full, combinationally from registered state.
- It SHALL NOT depend on data_out_ready.
- Push while full is therefore impossible, even when a pop happens in the same cycle.
REQ-011 Output SHALL be first-word-fall-through.
- data_out_valid = !empty.
- mdata_out/edata_out show the head entry.
REQ-012 While data_out_valid is 0, mdata_out and edata_out SHALL be driven to all zeros.
REQ-013 Latency SHALL be one cycle: data pushed at edge N is presented with data_out_valid=1 in the cycle following edge N.
REQ-014 Push and pop on the same edge SHALL leave count unchanged and advance both pointers.
REQ-015 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-017 Output data SHALL remain stable while data_out_valid=1 and data_out_ready=0.
REQ-018 Entries SHALL be delivered in strict push order with no loss or duplication.

Reset
REQ-019 Asserting rst SHALL immediately, independent of clk, set the following, including mid-transfer:
- pointers and count = 0
- empty = 1, full = 0
- data_in_ready = 1
- data_out_valid = 0
- mdata_out and edata_out = 0
REQ-020 Storage array contents SHALL NOT be reset; all contents are discarded on reset.
REQ-021 The first push SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-022 Macro MX_FIFO_BYPASS_EN SHALL select the empty-FIFO bypass.
- Defined: when empty, data_out_valid = data_in_valid and the outputs show mdata_in/edata_in combinationally.
- Defined: if data_out_ready=1 on that edge, the block is consumed without being stored and count stays 0; otherwise it is pushed normally.
- Undefined: REQ-011/REQ-013 apply unchanged, with no combinational path from input to output.

Verification
REQ-023 The bench SHALL cover these directed scenarios (DEPTH=4, IN_SIZE=2, MAN_WIDTH=4, EXP_WIDTH=8):
- Reset, then push {m=[3,5],e=0x7F} once with ready=1 -> next cycle valid=1, m=[3,5], e=0x7F; after pop: empty=1, outputs 0.
- Push 4 blocks with data_out_ready=0 -> full=1, data_in_ready=0, count=4; 5th valid is held off; drain yields blocks 1..4 in order.
- Fill to count=2, then push+pop every cycle for 10 cycles -> count stays 2, pointers wrap, order preserved.
- Full FIFO with data_out_ready=0 for 5 cycles -> head data unchanged; data_in_ready=0 throughout.
- Assert rst with count=3 between edges -> count=0, empty=1, data_out_valid=0 immediately; old data never appears.
- MX_FIFO_BYPASS_EN defined, empty, valid=1, ready=1, e=0x81 -> edata_out=0x81 in the same cycle, count stays 0. Undefined -> valid rises one cycle later.
